rf_write_arbiter: RTL

//   Shares the register file's single write port between the in-order pipeline WB stage and the multi-cycle unit (MDU).
//   MDU results go into a small FIFO and drain on cycles WB leaves the port idle.
//   A per-register scoreboard tracks outstanding MDU destinations and stalls ID when it reads one.
//   A starvation counter forces one pipeline stall so a queued MDU result can drain.

---
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter between pipeline WB and MDU results
// Queues MDU results, tracks pending MDU destinations, forces a pipeline stall when the queue head starves.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              mdu_issue,
  input  logic [ADDR_W-1:0] mdu_issue_reg,
  output logic              mdu_issue_ready,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic              id_re_1,
  input  logic [ADDR_W-1:0] id_addr_1,
  input  logic              id_re_2,
  input  logic [ADDR_W-1:0] id_addr_2,
  output logic              id_stall,
  output logic              pipe_stall
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_next;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_reg  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;

  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic              wb_req;
  logic              force_drain;
  logic              head_own;
  logic              push;
  logic              pop;
  logic              reserve;
  logic              hazard_1;
  logic              hazard_2;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign head_reg    = fifo_reg[rd_ptr];
  assign head_data   = fifo_data[rd_ptr];
  assign wb_req      = wb_we && (wb_write_reg != '0);
  assign force_drain = (starve_cnt == SC_W'(STARVE_MAX)) && !fifo_empty;

  // The head takes the port when forced, or whenever WB leaves it idle.
  assign head_own = !rst && (force_drain || (!wb_req && !fifo_empty));
  assign pop      = head_own;

  // Results for register 0 are acknowledged but never queued.
  assign push    = !rst && mdu_valid && !fifo_full && (mdu_reg != '0);
  assign reserve = mdu_issue && mdu_issue_ready && (mdu_issue_reg != '0);

  assign mdu_ready       = !rst && !fifo_full;
  assign mdu_issue_ready = !rst && !pend[mdu_issue_reg];

  assign rf_we         = head_own || (!rst && wb_req);
  assign rf_write_reg  = head_own ? head_reg  : wb_write_reg;
  assign rf_write_data = head_own ? head_data : wb_write_data;
  assign pipe_stall    = !rst && force_drain;

  // Reading a register that drains this very cycle is safe: the register file forwards it.
  assign hazard_1 = id_re_1 && (id_addr_1 != '0) && pend[id_addr_1]
                    && !(pop && (head_reg == id_addr_1));
  assign hazard_2 = id_re_2 && (id_addr_2 != '0) && pend[id_addr_2]
                    && !(pop && (head_reg == id_addr_2));
  assign id_stall = !rst && (hazard_1 || hazard_2);

  always_comb begin
    pend_next = pend;
    if (pop) begin
      pend_next[head_reg] = 1'b0;
    end
    if (reserve) begin
      pend_next[mdu_issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      pend <= pend_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop || fifo_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mdu_data;
      fifo_reg[wr_ptr]  <= mdu_reg;
    end
  end

endmodule
